// File: rtl/mag_input_framer.sv
// mag_input_framer: assembles signed (X,Y) byte pairs from a strobed byte
// stream and queues them in a show-ahead FIFO for the magnitude calculator.
// A byte strobed with in_sof is the X component; the next plain strobe is Y.
// Optional feature: define MAG_FRAMER_OVF_FLAG_EN to get a sticky ovf_flag
// that records dropped pairs (cleared by clr_ovf). Without it ovf_flag is 0.
module mag_input_framer #(
  parameter int DEPTH = 4  // FIFO depth in pairs: 2, 4 or 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_byte,
  input  logic                     in_stb,
  input  logic                     in_sof,
  output logic [7:0]               out_x,
  output logic [7:0]               out_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf_flag,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    WAIT_X,  // no X component held
    WAIT_Y   // X component held in x_hold, waiting for Y
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      x_hold;
  logic            load_x;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            drop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [15:0]     mem [DEPTH];

  // Framer state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_X;
    else        state <= state_nxt;
  end

  // Framer next-state and decode of X-load / pair-push requests.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    load_x    = 1'b0;
    push_req  = 1'b0;
    case (state)
      WAIT_X: begin
        if (in_stb && in_sof) begin
          load_x    = 1'b1;
          state_nxt = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (in_stb) begin
          if (in_sof) begin
            load_x = 1'b1;            // resync: newer X replaces held X
          end else begin
            push_req  = 1'b1;         // pair complete, leave even if dropped
            state_nxt = WAIT_X;
          end
        end
      end
      default: state_nxt = WAIT_X;
    endcase
  end

  // A full FIFO still accepts a pair when the head leaves in the same cycle.
  assign pop       = out_valid && out_ready;
  assign push      = push_req && ((count != FULL) || pop);
  assign drop      = push_req && !push;
  assign out_valid = (count != '0);
  assign level     = count;
  assign out_x     = out_valid ? mem[rd_ptr][15:8] : 8'h00;
  assign out_y     = out_valid ? mem[rd_ptr][7:0]  : 8'h00;

  // Holding register for the X component of the pair being framed.
  always_ff @(posedge clk) begin
    if (!rst_n)      x_hold <= 8'h00;
    else if (load_x) x_hold <= in_byte;
  end

  // Pair storage.
  // NOTE: the storage array is deliberately not reset; count and the
  // pointers define which entries are live and outputs are masked to 0
  // when empty, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {x_hold, in_byte};
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef MAG_FRAMER_OVF_FLAG_EN
  // Sticky overflow flag: a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)       ovf_flag <= 1'b0;
    else if (drop)    ovf_flag <= 1'b1;
    else if (clr_ovf) ovf_flag <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{clr_ovf, drop};
  assign ovf_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_mag_input_framer.sv
// Testbench for mag_input_framer (DEPTH=4). Drives a vector table and a few
// hand-written sequences; a queue of expected pairs is filled when pairs are
// framed and drained as the DUT hands them downstream.
module tb_mag_input_framer;

  localparam int DEPTH = 4;
`ifdef MAG_FRAMER_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [7:0]             in_byte;
  logic                   in_stb;
  logic                   in_sof;
  logic [7:0]             out_x;
  logic [7:0]             out_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf_flag;
  logic                   clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] sb[$];
  logic        m_wait_y = 1'b0;
  logic [7:0]  m_xhold  = 8'h00;
  logic        m_ovf    = 1'b0;

  typedef struct {
    logic       stb;
    logic       sof;
    logic [7:0] b;
    logic       rdy;
    int         exp_level;
    logic       exp_valid;
    logic [7:0] exp_x;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  mag_input_framer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_stb    (in_stb),
    .in_sof    (in_sof),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf_flag  (ovf_flag),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the model, check outputs #1 after the edge.
  task automatic cycle(input logic r, input logic stb, input logic sof,
                       input logic [7:0] b, input logic rdy, input logic clr);
    logic do_pop;
    logic drop;
    rst_n     = r;
    in_stb    = stb;
    in_sof    = sof;
    in_byte   = b;
    out_ready = rdy;
    clr_ovf   = clr;
    drop      = 1'b0;
    do_pop    = r && rdy && (sb.size() != 0);
    if (do_pop) begin
      check("pop_data", {16'h0, out_x, out_y}, {16'h0, sb[0]});
      void'(sb.pop_front());
    end
    if (!r) begin
      sb.delete();
      m_wait_y = 1'b0;
      m_xhold  = 8'h00;
      m_ovf    = 1'b0;
    end else if (stb) begin
      if (sof) begin
        m_xhold  = b;
        m_wait_y = 1'b1;
      end else if (m_wait_y) begin
        m_wait_y = 1'b0;
        if (sb.size() < DEPTH) sb.push_back({m_xhold, b});
        else                   drop = 1'b1;
      end
    end
    if (r && OVF_EN) begin
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check("level", 32'(level), 32'(sb.size()));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("head", {16'h0, out_x, out_y}, (sb.size() != 0) ? {16'h0, sb[0]} : 32'h0);
    check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
  endtask

  task automatic idle(input logic rdy, input logic clr);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, rdy, clr);
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y, input logic rdy);
    cycle(1'b1, 1'b1, 1'b1, x, rdy, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, y, rdy, 1'b0);
  endtask

  initial begin
    // stb sof byte rdy | level valid x y
    vecs[0] = '{1'b1, 1'b1, 8'h03, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h04, 1'b0, 1, 1'b1, 8'h03, 8'h04};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h55, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h7F, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 8'h80, 1'b0, 0, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 8'h01, 1'b0, 1, 1'b1, 8'h80, 8'h01};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h80, 8'h01};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h00};
    vecs[9] = '{1'b1, 1'b0, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h00};

    // Reset state.
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_xy", {16'h0, out_x, out_y}, 32'h0);

    // Basic pair, latency 1, resync and stray-byte handling.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].stb, vecs[i].sof, vecs[i].b, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_xy", i), {16'h0, out_x, out_y},
            {16'h0, vecs[i].exp_x, vecs[i].exp_y});
    end

    // Overflow: five pairs into a 4-deep FIFO, then drain in order.
    for (int i = 1; i <= 5; i++) send_pair(8'(i), 8'(i), 1'b0);
    check("full_level", 32'(level), 32'd4);
    check("ovf_after_drop", 32'(ovf_flag), 32'(OVF_EN));
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Full FIFO with a Y strobe coinciding with a pop: pair accepted.
    for (int i = 0; i < 4; i++) send_pair(8'h10 + 8'(i), 8'hF0 - 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    check("push_pop_full_level", 32'(level), 32'd4);
    check("push_pop_full_ovf", 32'(ovf_flag), 32'(OVF_EN));

    // Clear, then a drop in the same cycle as a clear keeps the flag set.
    idle(1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf_flag), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
    check("drop_and_clr_ovf", 32'(ovf_flag), 32'(OVF_EN));
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);

    // Reset mid-frame with three pairs queued; stray strobes ignored.
    for (int i = 0; i < 3; i++) send_pair(8'h20 + 8'(i), 8'h80 + 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_xy", {16'h0, out_x, out_y}, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    check("post_rst_plain_stb", 32'(level), 32'd0);
    send_pair(8'h81, 8'h7E, 1'b0);
    idle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
